// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs one instruction-memory request at a time and
// holds the returned word for the F/D register, dropping responses made stale by redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] InstrF_o,
  output logic [31:0] PCF_o,
  output logic [31:0] PCPlus4F_o,
  output logic        FetchBusy_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] ibuf;
  logic        kill;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Redirect targets are word aligned; the low two bits are simply masked off.
  assign target   = PCTargetE_i & ~32'h0000_0003;
  assign pc_plus4 = pcf + 32'd4;

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = pcf;
  assign PCF_o       = pcf;
  assign PCPlus4F_o  = pc_plus4;
  assign FetchBusy_o = (state != S_VALID);
  assign InstrF_o    = (state == S_VALID) ? ibuf : NOP_INSTR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pcf   <= RESET_PC;
      ibuf  <= NOP_INSTR;
      kill  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (PCSrcE_i) begin
            pcf <= target;
          end
          if (imem_ready_i) begin
            state <= S_WAIT;
            kill  <= PCSrcE_i;
          end
        end

        // kill marks the outstanding response as belonging to an abandoned PC.
        S_WAIT: begin
          if (PCSrcE_i) begin
            pcf <= target;
            if (imem_rvalid_i) begin
              state <= S_REQ;
              kill  <= 1'b0;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              ibuf  <= imem_rdata_i;
              state <= S_VALID;
            end
          end
        end

        S_VALID: begin
          if (PCSrcE_i) begin
            pcf   <= target;
            state <= S_REQ;
          end else if (!StallF_i) begin
            pcf   <= pc_plus4;
            state <= S_REQ;
          end
        end

        default: begin
          state <= S_REQ;
          kill  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the instruction memory by hand
// and scores delivered words against a queue filled when each response is driven.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF_i;
  logic        PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] InstrF_o;
  logic [31:0] PCF_o;
  logic [31:0] PCPlus4F_o;
  logic        FetchBusy_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .StallF_i     (StallF_i),
    .PCSrcE_i     (PCSrcE_i),
    .PCTargetE_i  (PCTargetE_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .InstrF_o     (InstrF_o),
    .PCF_o        (PCF_o),
    .PCPlus4F_o   (PCPlus4F_o),
    .FetchBusy_o  (FetchBusy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic stall, input logic pcsrc, input logic [31:0] tgt,
                               input logic ready, input logic rvalid, input logic [31:0] rdata);
    StallF_i      = stall;
    PCSrcE_i      = pcsrc;
    PCTargetE_i   = tgt;
    imem_ready_i  = ready;
    imem_rvalid_i = rvalid;
    imem_rdata_i  = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  // Called once the DUT should be holding a word: pop the oldest accepted response.
  task automatic checkScoreboard(input string tag);
    exp_t        e;
    logic [31:0] plus4;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e     = sb.pop_front();
      plus4 = e.pc + 32'd4;
      checkOutput({tag, "_busy"}, {31'd0, FetchBusy_o}, 32'd0);
      checkOutput({tag, "_instr"}, InstrF_o, e.instr);
      checkOutput({tag, "_pcf"}, PCF_o, e.pc);
      checkOutput({tag, "_pcplus4"}, PCPlus4F_o, plus4);
    end
  endtask

  task automatic checkIdle(input string tag, input logic req, input logic [31:0] addr);
    checkOutput({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
    checkOutput({tag, "_addr"}, imem_addr_o, addr);
    checkOutput({tag, "_busy"}, {31'd0, FetchBusy_o}, 32'd1);
    checkOutput({tag, "_instr"}, InstrF_o, NOP);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    checkIdle("reset", 1'b1, 32'h0);
    checkOutput("reset_pcplus4", PCPlus4F_o, 32'h4);
    #10;
    rst_n = 1'b1;

    // Basic fetch: accept, one-cycle response, word held.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkIdle("t1_c0", 1'b1, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093);
    expectWord(32'h0, 32'h0050_0093);
    checkIdle("t1_wait", 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkScoreboard("t1");

    // Stall holds the word and issues nothing.
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t2_instr", InstrF_o, 32'h0050_0093);
      checkOutput("t2_pcf", PCF_o, 32'h0);
      checkOutput("t2_req", {31'd0, imem_req_o}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkIdle("t1_next", 1'b1, 32'h4);

    // Redirect while waiting: the returned word is stale.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkIdle("t3_kill", 1'b0, 32'h100);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkIdle("t3_drop", 1'b1, 32'h100);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0113);
    expectWord(32'h100, 32'h0010_0113);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkScoreboard("t3_after");
    step();
    checkIdle("t3_next", 1'b1, 32'h104);

    // Redirect in the same cycle as acceptance; misaligned target bits masked.
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBADB_AD00);
    checkIdle("t4_wait", 1'b0, 32'h200);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkIdle("t4_drop", 1'b1, 32'h200);

    // Memory not ready for five cycles, then a single accept.
    for (int i = 0; i < 5; i++) begin
      step();
      checkIdle("t5_hold", 1'b1, 32'h200);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkIdle("t5_once", 1'b0, 32'h200);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0020_0193);
    expectWord(32'h200, 32'h0020_0193);
    checkIdle("t5_still", 1'b0, 32'h200);
    step();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    checkScoreboard("t5");

    // Redirect wins over stall in the valid state.
    step();
    applyStimulus(1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0);
    checkIdle("prio", 1'b1, 32'h300);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkIdle("req_redir", 1'b1, 32'h404);

    // Asynchronous reset while waiting for a response.
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkIdle("t6_wait", 1'b0, 32'h404);
    #3;
    rst_n = 1'b0;
    #1;
    checkIdle("t6_async", 1'b1, 32'h0);
    checkOutput("t6_pcplus4", PCPlus4F_o, 32'h4);
    #2;
    rst_n = 1'b1;

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkIdle("t6_top", 1'b1, 32'hFFFF_FFFC);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0030_0213);
    expectWord(32'hFFFF_FFFC, 32'h0030_0213);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkScoreboard("t6_wrap");
    step();
    checkIdle("t6_next", 1'b1, 32'h0);
    checkOutput("t6_next_pcplus4", PCPlus4F_o, 32'h4);

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
